// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch prefetch stage: FSM states, trap codes
// and the prefetch-queue entry layout.
package if_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_e;

   localparam logic [3:0] TRAP_INSTR_MISALIGNED = 4'd0;
   localparam logic [3:0] TRAP_INSTR_ACCESS     = 4'd1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        is_trap;
      logic [3:0]  trap_code;
   } if_entry_t;

   function automatic if_entry_t make_trap(input logic [31:0] pc, input logic [3:0] code);
      if_entry_t e;
      e           = '0;
      e.pc        = pc;
      e.is_trap   = 1'b1;
      e.trap_code = code;
      return e;
   endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with push, pop and flush.
// Flush discards every entry and takes priority over a same-cycle push or pop.
module if_fetch_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  if_entry_t                push_data,
   input  logic                     pop,
   input  logic                     flush,
   output if_entry_t                head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   if_entry_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (rst_i || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing reads it while count is zero.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush && !rst_i) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: Wishbone fetch FSM feeding a prefetch queue to decode.
// Define IF_BUS_TIMEOUT_EN to abandon bus accesses after TIMEOUT_CYCLES wait cycles.
//
//  state | meaning
//  IDLE  | decide next fetch: issue when queue has room, trap on misaligned pc
//  REQ   | bus access outstanding; response is pushed into the queue
//  DRAIN | access outstanding after a redirect; response is dropped
//  HALT  | fault queued; wait for a redirect
module if_prefetch_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
   parameter int          DEPTH          = 4,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        id_ready_i,
   output logic        id_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic        is_trap_o,
   output logic [3:0]  trap_code_o,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   fetch_state_e           state_q;
   fetch_state_e           state_d;
   logic [31:0]            fetch_pc;
   logic                   push;
   if_entry_t              push_data;
   if_entry_t              head;
   logic [$clog2(DEPTH):0] count;
   logic                   full;
   logic                   empty;
   logic                   bus_resp;
   logic                   timeout;

   assign bus_resp = wbm_ack_i || wbm_err_i;

`ifdef IF_BUS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] wait_cnt;

   // Reloads on any state change so each REQ/DRAIN visit gets the full budget.
   always_ff @(posedge clk_i) begin
      if (rst_i || (state_d != state_q) || !(state_q == REQ || state_q == DRAIN))
         wait_cnt <= WAIT_LOAD;
      else if (wait_cnt != '0)
         wait_cnt <= wait_cnt - TW'(1);
   end

   assign timeout = (state_q == REQ || state_q == DRAIN) && (wait_cnt == '0) && !bus_resp;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)                           fetch_pc <= RESET_ADDR;
      else if (redirect_i)                 fetch_pc <= redirect_pc_i;
      else if (state_q == REQ && wbm_ack_i) fetch_pc <= fetch_pc + 32'd4;
   end

   always_comb begin
      state_d = state_q;
      if (redirect_i) begin
         // The flush leaves the queue empty, so an aligned target can be fetched at once.
         if (state_q == REQ || state_q == DRAIN)
            state_d = (bus_resp || timeout) ? IDLE : DRAIN;
         else
            state_d = (redirect_pc_i[1:0] == 2'b00) ? REQ : IDLE;
      end else begin
         case (state_q)
            IDLE:    if (!full) state_d = (fetch_pc[1:0] == 2'b00) ? REQ : HALT;
            REQ: begin
               if (wbm_ack_i)                   state_d = IDLE;
               else if (wbm_err_i || timeout)   state_d = HALT;
            end
            DRAIN:   if (bus_resp || timeout) state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      push      = 1'b0;
      push_data = '0;
      wbm_cyc_o = (state_q == REQ) || (state_q == DRAIN);
      wbm_stb_o = (state_q == REQ) || (state_q == DRAIN);
      wbm_addr_o = fetch_pc;
      wbm_dat_o  = '0;
      wbm_sel_o  = 4'hF;
      wbm_we_o   = 1'b0;
      if (!redirect_i) begin
         case (state_q)
            IDLE: begin
               if (!full && fetch_pc[1:0] != 2'b00) begin
                  push      = 1'b1;
                  push_data = make_trap(fetch_pc, TRAP_INSTR_MISALIGNED);
               end
            end
            REQ: begin
               if (wbm_ack_i) begin
                  push            = 1'b1;
                  push_data.instr = wbm_dat_i;
                  push_data.pc    = fetch_pc;
               end else if (wbm_err_i || timeout) begin
                  push      = 1'b1;
                  push_data = make_trap(fetch_pc, TRAP_INSTR_ACCESS);
               end
            end
            default: push = 1'b0;
         endcase
      end
   end

   if_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (push),
      .push_data (push_data),
      .pop       (id_ready_i && !empty),
      .flush     (redirect_i),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Head fields are forced to zero while the queue is empty.
   assign id_valid_o  = (count != '0);
   assign instr_o     = id_valid_o ? head.instr : '0;
   assign pc_o        = id_valid_o ? head.pc : '0;
   assign pc4_o       = id_valid_o ? head.pc + 32'd4 : '0;
   assign is_trap_o   = id_valid_o && head.is_trap;
   assign trap_code_o = id_valid_o ? head.trap_code : '0;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_if_prefetch_stage;

   localparam int DEPTH  = 4;
   localparam int TO_CYC = 8;
`ifdef IF_BUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int M_IDLE = 0, M_BUS = 1, M_DRAIN = 2, M_HALT = 3;

   logic        clk_i = 1'b0;
   logic        rst_i, redirect_i, id_ready_i, wbm_ack_i, wbm_err_i;
   logic [31:0] redirect_pc_i, wbm_dat_i;
   logic        id_valid_o, is_trap_o, wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [31:0] instr_o, pc_o, pc4_o, wbm_addr_o, wbm_dat_o;
   logic [3:0]  trap_code_o, wbm_sel_o;

   always #5 clk_i = ~clk_i;

   if_prefetch_stage #(.RESET_ADDR(32'h0), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .id_ready_i(id_ready_i), .id_valid_o(id_valid_o), .instr_o(instr_o), .pc_o(pc_o),
      .pc4_o(pc4_o), .is_trap_o(is_trap_o), .trap_code_o(trap_code_o),
      .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      bit          trap;
      logic [3:0]  code;
   } exp_t;

   exp_t        mq[$];
   logic [31:0] mpc;
   int          mode, wait_n;
   int          checks = 0, failures = 0;

   bit          slave_auto, rand_wait, rand_err, fixed13;
   logic [31:0] hold_addr, err_addr;
   int          s_wait;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return fixed13 ? 32'h0000_0013 : (a ^ 32'h5A5A_0003);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour for one clock edge, from the inputs presented in that cycle.
   task automatic model_step();
      int  n    = mq.size();
      bit  resp = wbm_ack_i || wbm_err_i;
      bit  on_bus = (mode == M_BUS || mode == M_DRAIN);
      bit  timed;
      int  old_mode = mode;
      exp_t e;
      if (rst_i) begin
         mq.delete(); mpc = 32'h0; mode = M_IDLE; wait_n = 0;
         return;
      end
      if (on_bus) wait_n++;
      timed = TO_EN && on_bus && (wait_n >= TO_CYC) && !resp;
      if (redirect_i) begin
         mq.delete();
         mpc = redirect_pc_i;
         if (on_bus) mode = (resp || timed) ? M_IDLE : M_DRAIN;
         else        mode = (redirect_pc_i[1:0] == 2'b00) ? M_BUS : M_IDLE;
      end else begin
         if (id_ready_i && n > 0) void'(mq.pop_front());
         case (mode)
            M_IDLE: if (n < DEPTH) begin
               if (mpc[1:0] == 2'b00) mode = M_BUS;
               else begin
                  e = '{instr: 32'h0, pc: mpc, trap: 1'b1, code: 4'd0};
                  mq.push_back(e); mode = M_HALT;
               end
            end
            M_BUS: if (wbm_ack_i) begin
               e = '{instr: wbm_dat_i, pc: mpc, trap: 1'b0, code: 4'd0};
               mq.push_back(e); mpc = mpc + 32'd4; mode = M_IDLE;
            end else if (wbm_err_i || timed) begin
               e = '{instr: 32'h0, pc: mpc, trap: 1'b1, code: 4'd1};
               mq.push_back(e); mode = M_HALT;
            end
            M_DRAIN: if (resp || timed) mode = M_IDLE;
            default: ;
         endcase
      end
      if (mode != old_mode) wait_n = 0;
   endtask

   task automatic compare();
      bit busy = (mode == M_BUS || mode == M_DRAIN);
      chk("id_valid", id_valid_o, mq.size() > 0);
      chk("cyc", wbm_cyc_o, busy);
      chk("stb", wbm_stb_o, busy);
      chk("addr", wbm_addr_o, mpc);
      chk("sel", wbm_sel_o, 4'hF);
      chk("we", wbm_we_o, 1'b0);
      chk("dat_o", wbm_dat_o, 32'h0);
      if (mq.size() > 0) begin
         chk("pc", pc_o, mq[0].pc);
         chk("pc4", pc4_o, mq[0].pc + 32'd4);
         chk("is_trap", is_trap_o, mq[0].trap);
         chk("trap_code", trap_code_o, mq[0].code);
         if (!mq[0].trap) chk("instr", instr_o, mq[0].instr);
      end else begin
         chk("idle_instr", instr_o, 32'h0);
         chk("idle_pc", pc_o, 32'h0);
      end
   endtask

   task automatic slave_drive();
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'h0;
      if (slave_auto && wbm_cyc_o && wbm_stb_o && wbm_addr_o != hold_addr) begin
         if (s_wait > 0) s_wait--;
         else begin
            if (wbm_addr_o == err_addr || (rand_err && $urandom_range(0, 15) == 0))
               wbm_err_i = 1'b1;
            else begin
               wbm_ack_i = 1'b1;
               wbm_dat_i = mem_word(wbm_addr_o);
            end
            s_wait = rand_wait ? $urandom_range(0, 3) : 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
      compare();
      slave_drive();
   endtask

   task automatic do_reset();
      rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b0;
      slave_auto = 1'b1; rand_wait = 1'b0; rand_err = 1'b0; fixed13 = 1'b0;
      hold_addr = 32'hFFFF_FFFF; err_addr = 32'hFFFF_FFFF; s_wait = 0;
      tick(); tick();
      rst_i = 1'b0;
   endtask

   task automatic wait_cyc(input int budget, input string name);
      for (int i = 0; i < budget && !wbm_cyc_o; i++) tick();
      if (!wbm_cyc_o) chk(name, 32'd0, 32'd1);
   endtask

   task automatic wait_valid(input int budget, input string name);
      for (int i = 0; i < budget && !id_valid_o; i++) tick();
      if (!id_valid_o) chk(name, 32'd0, 32'd1);
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_i = 1'b1; redirect_pc_i = pc;
      tick();
      redirect_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b0;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'h0;
      mq.delete(); mpc = 32'h0; mode = M_IDLE; wait_n = 0;
      @(negedge clk_i);

      // Fill the queue with 0x13 at 0x0..0xC; no bus traffic while full; one pop refetches 0x10.
      do_reset();
      chk("rst_valid", id_valid_o, 1'b0);
      chk("rst_cyc", wbm_cyc_o, 1'b0);
      chk("rst_sel", wbm_sel_o, 4'hF);
      chk("rst_addr", wbm_addr_o, 32'h0);
      chk("rst_pc4", pc4_o, 32'h0);
      fixed13 = 1'b1;
      repeat (12) tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_full_cyc", wbm_cyc_o, 1'b0);
      end
      chk("t1_head_pc", pc_o, 32'h0);
      chk("t1_head_instr", instr_o, 32'h0000_0013);
      id_ready_i = 1'b1; tick(); id_ready_i = 1'b0;
      chk("t1_after_pop_pc", pc_o, 32'h4);
      wait_cyc(5, "t1_refetch_seen");
      chk("t1_refetch_addr", wbm_addr_o, 32'h10);
      repeat (2) tick();

      // Redirect during the fetch at 0x8; the late ack is discarded.
      do_reset();
      id_ready_i = 1'b1; hold_addr = 32'h8;
      for (int i = 0; i < 20 && !(wbm_cyc_o && wbm_addr_o == 32'h8); i++) tick();
      chk("t2_req8_seen", wbm_cyc_o && wbm_addr_o == 32'h8, 1'b1);
      slave_auto = 1'b0;
      do_redirect(32'h100);
      chk("t2_drain_cyc", wbm_cyc_o, 1'b1);
      chk("t2_drain_valid", id_valid_o, 1'b0);
      tick(); tick();
      wbm_ack_i = 1'b1; wbm_dat_i = 32'hDEAD_BEEF;
      tick();
      chk("t2_stale_dropped", id_valid_o, 1'b0);
      chk("t2_idle_cyc", wbm_cyc_o, 1'b0);
      slave_auto = 1'b1; hold_addr = 32'hFFFF_FFFF;
      wait_cyc(5, "t2_refetch_seen");
      chk("t2_refetch_addr", wbm_addr_o, 32'h100);
      wait_valid(6, "t2_entry_seen");
      chk("t2_entry_pc", pc_o, 32'h100);
      chk("t2_entry_instr", instr_o, 32'h100 ^ 32'h5A5A_0003);

      // Misaligned redirect target: trap code 0 with no bus access, then halt.
      do_reset();
      do_redirect(32'h102);
      for (int i = 0; i < 6 && !id_valid_o; i++) begin
         chk("t3_no_bus", wbm_cyc_o, 1'b0);
         tick();
      end
      chk("t3_valid", id_valid_o, 1'b1);
      chk("t3_is_trap", is_trap_o, 1'b1);
      chk("t3_code", trap_code_o, 4'd0);
      chk("t3_pc", pc_o, 32'h102);
      repeat (5) tick();
      chk("t3_halted_cyc", wbm_cyc_o, 1'b0);

      // Bus error at 0x20 queues an access fault; redirect to 0x40 resumes.
      do_reset();
      err_addr = 32'h20;
      do_redirect(32'h20);
      wait_valid(8, "t4_trap_seen");
      chk("t4_is_trap", is_trap_o, 1'b1);
      chk("t4_code", trap_code_o, 4'd1);
      chk("t4_pc", pc_o, 32'h20);
      id_ready_i = 1'b1; tick(); id_ready_i = 1'b0;
      repeat (4) tick();
      chk("t4_halted_cyc", wbm_cyc_o, 1'b0);
      chk("t4_halted_valid", id_valid_o, 1'b0);
      err_addr = 32'hFFFF_FFFF;
      do_redirect(32'h40);
      chk("t4_resume_cyc", wbm_cyc_o, 1'b1);
      chk("t4_resume_addr", wbm_addr_o, 32'h40);
      repeat (3) tick();

      // Redirect together with ack and pop on a nearly full queue.
      do_reset();
      repeat (12) tick();
      id_ready_i = 1'b1; tick(); id_ready_i = 1'b0;
      slave_auto = 1'b0;
      wait_cyc(6, "t5_req_seen");
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678; id_ready_i = 1'b1;
      redirect_i = 1'b1; redirect_pc_i = 32'h200;
      tick();
      redirect_i = 1'b0; id_ready_i = 1'b0; slave_auto = 1'b1;
      chk("t5_flushed", id_valid_o, 1'b0);
      chk("t5_idle_cyc", wbm_cyc_o, 1'b0);
      tick();
      chk("t5_next_cyc", wbm_cyc_o, 1'b1);
      chk("t5_next_addr", wbm_addr_o, 32'h200);

`ifdef IF_BUS_TIMEOUT_EN
      // Silent slave: the access is abandoned after TO_CYC cycles with an access fault.
      begin
         int n;
         do_reset();
         hold_addr = 32'h0;
         wait_cyc(4, "to_req_seen");
         n = 0;
         while (wbm_cyc_o && n < 20) begin tick(); n++; end
         chk("to_cyc_len", n, TO_CYC);
         chk("to_valid", id_valid_o, 1'b1);
         chk("to_code", trap_code_o, 4'd1);
         chk("to_is_trap", is_trap_o, 1'b1);
      end
`endif

      // Random traffic: wait states, bus errors, redirects and decode back-pressure.
      do_reset();
      rand_wait = 1'b1; rand_err = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] rpc;
         id_ready_i = ($urandom_range(0, 1) == 1);
         redirect_i = ($urandom_range(0, 23) == 0);
         rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         redirect_pc_i = rpc;
         tick();
      end
      redirect_i = 1'b0; id_ready_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
